// File: rtl/rgb2gray_convert.sv
// rgb2gray_convert
// Three-stage RGB-to-luma pipeline with delayed sync framing and an
// input-side frame geometry checker that reports sticky error flags.
// Y = (77*R + 150*G + 29*B + 128) >> 8, saturated to the output width.

module rgb2gray_convert #(
    parameter int NB_IMG_HORI = 960,
    parameter int NB_IMG_VERT = 640,
    parameter int WD_IMG_DATA = 8,
    parameter int WD_ERR_INFO = 4
) (
    input  logic                       i_sys_clk,
    input  logic                       i_sys_reset,
    input  logic                       s_img_rgb_c_fsync,
    input  logic                       s_img_rgb_c_vsync,
    input  logic                       s_img_rgb_c_hsync,
    input  logic [3*WD_IMG_DATA-1:0]   s_img_rgb_p_mdat0,
    output logic                       m_img_gray_c_fsync,
    output logic                       m_img_gray_c_vsync,
    output logic                       m_img_gray_c_hsync,
    output logic [WD_IMG_DATA-1:0]     m_img_gray_y_mdat0,
    output logic [WD_ERR_INFO-1:0]     m_err_rgb2gray_info1
);

    localparam int W   = WD_IMG_DATA;
    localparam int WP  = WD_IMG_DATA + 8;
    localparam int WS  = WD_IMG_DATA + 9;
    // Counter widths leave the all-ones saturation value above the nominal count,
    // so an overlong line or frame is never mistaken for a correct one.
    localparam int WPC = $clog2(NB_IMG_HORI + 2);
    localparam int WLC = $clog2(NB_IMG_VERT + 2);

    localparam logic [7:0]     COEF_R  = 8'd77;
    localparam logic [7:0]     COEF_G  = 8'd150;
    localparam logic [7:0]     COEF_B  = 8'd29;
    localparam logic [WS-1:0]  ROUND   = WS'(128);
    localparam logic [W:0]     Y_MAX   = {1'b0, {W{1'b1}}};
    localparam logic [WPC-1:0] HORI    = WPC'(NB_IMG_HORI);
    localparam logic [WLC-1:0] VERT    = WLC'(NB_IMG_VERT);

    logic [W-1:0]   pix_r;
    logic [W-1:0]   pix_g;
    logic [W-1:0]   pix_b;

    logic [2:0]     fs_sr;
    logic [2:0]     vs_sr;
    logic [2:0]     hs_sr;

    logic [WP-1:0]  prod_r;
    logic [WP-1:0]  prod_g;
    logic [WP-1:0]  prod_b;
    logic [WS-1:0]  sum;
    logic [W:0]     y_shift;
    logic [W-1:0]   y_sat;
    logic [W-1:0]   y_out;

    logic           fsync_q;
    logic           vsync_q;
    logic           fs_rise;
    logic           fs_fall;
    logic           vs_rise;
    logic           vs_fall;
    logic [WPC-1:0] pix_cnt;
    logic [WLC-1:0] line_cnt;
    logic [WLC-1:0] line_cnt_nxt;
    logic           armed;
    logic [3:0]     err_set;
    logic [3:0]     err;

    assign pix_r = s_img_rgb_p_mdat0[3*W-1 -: W];
    assign pix_g = s_img_rgb_p_mdat0[2*W-1 -: W];
    assign pix_b = s_img_rgb_p_mdat0[W-1:0];

    // Sync delay lines; hs_sr doubles as the per-stage valid bits.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            fs_sr <= '0;
            vs_sr <= '0;
            hs_sr <= '0;
        end else begin
            fs_sr <= {fs_sr[1:0], s_img_rgb_c_fsync};
            vs_sr <= {vs_sr[1:0], s_img_rgb_c_vsync};
            hs_sr <= {hs_sr[1:0], s_img_rgb_c_hsync};
        end
    end

    // Stage 1: weighted products, captured only on a pixel strobe.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            prod_r <= '0;
            prod_g <= '0;
            prod_b <= '0;
        end else if (s_img_rgb_c_hsync) begin
            prod_r <= WP'(pix_r) * WP'(COEF_R);
            prod_g <= WP'(pix_g) * WP'(COEF_G);
            prod_b <= WP'(pix_b) * WP'(COEF_B);
        end
    end

    // Stage 2: rounded sum of products.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            sum <= '0;
        end else if (hs_sr[0]) begin
            sum <= WS'(prod_r) + WS'(prod_g) + WS'(prod_b) + ROUND;
        end
    end

    // Divide by 256 and clamp to the output range.
    always_comb begin
        y_shift = sum[WS-1:8];
        y_sat   = (y_shift > Y_MAX) ? {W{1'b1}} : y_shift[W-1:0];
    end

    // Stage 3: output pixel register, holds between strobes.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            y_out <= '0;
        end else if (hs_sr[1]) begin
            y_out <= y_sat;
        end
    end

    assign m_img_gray_c_fsync = fs_sr[2];
    assign m_img_gray_c_vsync = vs_sr[2];
    assign m_img_gray_c_hsync = hs_sr[2];
    assign m_img_gray_y_mdat0 = y_out;

    // Registered copies for edge detection. They keep tracking the inputs during
    // reset so that releasing reset mid-frame does not fake an fsync/vsync rise.
    always_ff @(posedge i_sys_clk) begin
        fsync_q <= s_img_rgb_c_fsync;
        vsync_q <= s_img_rgb_c_vsync;
    end

    always_comb begin
        fs_rise = s_img_rgb_c_fsync  & ~fsync_q;
        fs_fall = ~s_img_rgb_c_fsync & fsync_q;
        vs_rise = s_img_rgb_c_vsync  & ~vsync_q;
        vs_fall = ~s_img_rgb_c_vsync & vsync_q;
    end

    // Pixels per line; a strobe coinciding with the vsync rise is the first pixel.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            pix_cnt <= '0;
        end else if (vs_rise) begin
            pix_cnt <= WPC'(s_img_rgb_c_hsync);
        end else if (s_img_rgb_c_hsync && s_img_rgb_c_vsync && (pix_cnt != '1)) begin
            pix_cnt <= pix_cnt + WPC'(1);
        end
    end

    // Next line count includes a line ending in the same cycle the frame ends.
    always_comb begin
        line_cnt_nxt = line_cnt;
        if (vs_fall && fsync_q && (line_cnt != '1)) begin
            line_cnt_nxt = line_cnt + WLC'(1);
        end
    end

    // Lines per frame.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            line_cnt <= '0;
        end else if (fs_rise) begin
            line_cnt <= '0;
        end else begin
            line_cnt <= line_cnt_nxt;
        end
    end

    // Geometry checks are only trusted once a whole frame has been seen from its start.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            armed <= 1'b0;
        end else if (fs_rise) begin
            armed <= 1'b1;
        end
    end

    always_comb begin
        err_set[0] = armed & vs_fall & (pix_cnt != HORI);
        err_set[1] = armed & fs_fall & (line_cnt_nxt != VERT);
        err_set[2] = s_img_rgb_c_hsync & ~s_img_rgb_c_vsync;
        err_set[3] = s_img_rgb_c_vsync & ~s_img_rgb_c_fsync;
    end

    // Sticky flags: fsync rise clears old flags but a same-cycle new flag still lands.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            err <= '0;
        end else begin
            err <= (fs_rise ? 4'b0000 : err) | err_set;
        end
    end

    // Upper error bits beyond the defined four read as zero.
    always_comb begin
        m_err_rgb2gray_info1      = '0;
        m_err_rgb2gray_info1[3:0] = err;
    end

endmodule

// File: tb/tb_rgb2gray_convert.sv
// tb_rgb2gray_convert
// Scoreboard bench: stimulus pushes expected luma into a queue, a negedge monitor
// pops on every output strobe. Frame geometry is reduced to keep runtime short.

module tb_rgb2gray_convert;

    localparam int W = 8;
    localparam int H = 64;
    localparam int V = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fsync = 1'b0;
    logic          vsync = 1'b0;
    logic          hsync = 1'b0;
    logic [23:0]   rgb = '0;
    logic          m_fs;
    logic          m_vs;
    logic          m_hs;
    logic [W-1:0]  m_y;
    logic [3:0]    m_err;

    rgb2gray_convert #(
        .NB_IMG_HORI (H),
        .NB_IMG_VERT (V),
        .WD_IMG_DATA (W),
        .WD_ERR_INFO (4)
    ) dut (
        .i_sys_clk            (clk),
        .i_sys_reset          (rst),
        .s_img_rgb_c_fsync    (fsync),
        .s_img_rgb_c_vsync    (vsync),
        .s_img_rgb_c_hsync    (hsync),
        .s_img_rgb_p_mdat0    (rgb),
        .m_img_gray_c_fsync   (m_fs),
        .m_img_gray_c_vsync   (m_vs),
        .m_img_gray_c_hsync   (m_hs),
        .m_img_gray_y_mdat0   (m_y),
        .m_err_rgb2gray_info1 (m_err)
    );

    always #5 clk = ~clk;

    int       checks = 0;
    int       errors = 0;
    int       exp_q[$];
    logic [2:0] hist [3] = '{3'b000, 3'b000, 3'b000};
    int       last_y = 0;
    int       out_cnt = 0;
    bit       err_watch = 1'b0;

    function automatic int luma(input int r, input int g, input int b);
        int y;
        y = (77 * r + 150 * g + 29 * b + 128) / 256;
        if (y > 255) y = 255;
        return y;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: record what was presented at each active edge.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            hist[0] = 3'b000;
            hist[1] = 3'b000;
            hist[2] = 3'b000;
            last_y  = 0;
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = {fsync, vsync, hsync};
            if (hsync) exp_q.push_back(luma(int'(rgb[23:16]), int'(rgb[15:8]), int'(rgb[7:0])));
        end
    end

    // Monitor: syncs delayed by three, data popped in order, data holds between strobes.
    always @(negedge clk) begin
        int e;
        check("fsync_out", m_fs, hist[2][2]);
        check("vsync_out", m_vs, hist[2][1]);
        check("hsync_out", m_hs, hist[2][0]);
        if (m_hs) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got gray %0d expected no strobe", m_y);
            end else begin
                e = exp_q.pop_front();
                check("gray", m_y, e);
                last_y = e;
            end
        end else begin
            check("gray_hold", m_y, last_y);
        end
        if (err_watch) check("err_clean", m_err, 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input int npix, input int rst_at, input int exp_bit0);
        vsync = 1'b1;
        for (int p = 0; p < npix; p++) begin
            if (p == rst_at) begin
                rst   = 1'b1;
                hsync = 1'b1;
                rgb   = 24'($urandom);
                tick();
                check("rst_fsync_out", m_fs, 0);
                check("rst_vsync_out", m_vs, 0);
                check("rst_hsync_out", m_hs, 0);
                check("rst_gray_out", m_y, 0);
                check("rst_err_out", m_err, 0);
                hsync = 1'b0;
                tick();
                rst = 1'b0;
            end
            rgb   = 24'($urandom);
            hsync = 1'b1;
            tick();
            hsync = 1'b0;
            tick();
        end
        vsync = 1'b0;
        tick();
        if (exp_bit0 >= 0) check("err_bit0_at_vsync_fall", m_err[0], exp_bit0);
    endtask

    task automatic send_frame(input int short_line, input int rst_line, input bit watch);
        fsync = 1'b1;
        tick();
        check("err_clear_on_fsync_rise", m_err, 0);
        err_watch = watch;
        for (int l = 0; l < V; l++) begin
            send_line((l == short_line) ? H - 1 : H,
                      (l == rst_line) ? H / 2 : -1,
                      (l == short_line) ? 1 : -1);
        end
        fsync = 1'b0;
        tick();
        tick();
        err_watch = 1'b0;
    endtask

    logic [23:0] dir_px [6] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF, 24'h000000, 24'h0A141E};
    int          dir_y  [6] = '{77, 149, 29, 255, 0, 18};

    initial begin
        int c0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_fsync", m_fs, 0);
        check("reset_vsync", m_vs, 0);
        check("reset_hsync", m_hs, 0);
        check("reset_gray", m_y, 0);
        check("reset_err", m_err, 0);

        // Directed colours, each checked exactly three cycles after its strobe.
        fsync = 1'b1;
        vsync = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            rgb   = dir_px[i];
            hsync = 1'b1;
            tick();
            hsync = 1'b0;
            tick();
            tick();
            check("directed_hsync_at_3", m_hs, 1);
            check("directed_gray", m_y, dir_y[i]);
            tick();
        end

        // Back-to-back burst.
        c0 = out_cnt;
        for (int i = 0; i < 16; i++) begin
            rgb   = 24'($urandom);
            hsync = 1'b1;
            tick();
        end
        hsync = 1'b0;
        repeat (4) tick();
        check("burst_strobes", out_cnt - c0, 16);
        vsync = 1'b0;
        tick();
        fsync = 1'b0;
        tick();
        tick();

        // Good frame.
        out_cnt = 0;
        send_frame(-1, -1, 1'b1);
        repeat (4) tick();
        check("frame_pixels", out_cnt, H * V);
        check("err_after_good_frame", m_err, 0);

        // Frame with one short line: bit0 sticky through the frame.
        send_frame(3, -1, 1'b0);
        check("err_short_line_frame_end", m_err, 1);

        // Following good frame clears it at fsync rise.
        out_cnt = 0;
        send_frame(-1, -1, 1'b1);
        repeat (4) tick();
        check("frame_pixels_2", out_cnt, H * V);

        // Strobe outside a line: flagged and still forwarded.
        fsync = 1'b1;
        tick();
        c0    = out_cnt;
        rgb   = 24'($urandom);
        hsync = 1'b1;
        tick();
        hsync = 1'b0;
        tick();
        check("err_bit2", m_err[2], 1);
        repeat (3) tick();
        check("bit2_pixel_forwarded", out_cnt - c0, 1);
        fsync = 1'b0;
        tick();
        vsync = 1'b1;
        tick();
        check("err_bit3", m_err[3], 1);
        vsync = 1'b0;
        tick();
        tick();

        // Reset in the middle of a line; truncated frame reports no geometry errors.
        send_frame(-1, 2, 1'b0);
        check("err_masked_after_reset", m_err, 0);

        out_cnt = 0;
        send_frame(-1, -1, 1'b1);
        repeat (4) tick();
        check("frame_pixels_after_reset", out_cnt, H * V);
        check("err_after_reset_frame", m_err, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/rgb2gray_convert.md
# rgb2gray_convert

Pipelined RGB-to-luma converter that sits directly upstream of histogram equalization. It accepts a packed 8:8:8 RGB pixel stream using the fsync/vsync/hsync image interface. It emits an 8-bit gray stream with the same sync framing, delayed by a fixed pipeline latency. It also checks frame geometry and reports violations on a sticky error bus.

## Interface
- NB_IMG_HORI, 960, pixels per line (hsync strobes per vsync window)
- NB_IMG_VERT, 640, lines per frame (vsync windows per fsync window)
- WD_IMG_DATA, 8, bits per colour component and per gray output
- WD_ERR_INFO, 4, error bus width (bits 3:0 defined; extra bits tie to 0)
- i_sys_clk  in  1  sole clock, all logic on rising edge
- i_sys_reset  in  1  reset, synchronous, active-high
- s_img_rgb_c_fsync  in  1  high for the whole frame
- s_img_rgb_c_vsync  in  1  high for the whole line
- s_img_rgb_c_hsync  in  1  one-cycle strobe per valid pixel
- s_img_rgb_p_mdat0  in  3*WD_IMG_DATA  pixel {R,G,B}, R in MSBs, valid when hsync=1
- m_img_gray_c_fsync  out  1  fsync delayed by latency
- m_img_gray_c_vsync  out  1  vsync delayed by latency
- m_img_gray_c_hsync  out  1  hsync delayed by latency
- m_img_gray_y_mdat0  out  WD_IMG_DATA  gray pixel, valid when m hsync=1
- m_err_rgb2gray_info1  out  WD_ERR_INFO  sticky geometry error flags

## Operation
- Luma: Y = (77·R + 150·G + 29·B + 128) >> 8, integer, unsigned.
- Sum width: WD_IMG_DATA+9 bits, so the sum never overflows.
- Result saturates to 2^WD_IMG_DATA−1. This is unreachable at W=8, but the saturation logic is required.
- Pipeline stages:
  - S1 registers the three products. Capture occurs only when hsync=1.
  - S2 registers the sum with the rounding constant.
  - S3 registers the shifted and saturated Y.
- Pipeline stages advance on every cycle. Data registers load only when their stage-valid bit is 1, otherwise they hold.
- Output data holds its last value while m hsync=0.
- fsync, vsync and hsync each pass through a 3-deep shift register, aligned with the data.
- There is no backpressure. Pixel rate can be up to one per cycle (hsync held high continuously).
- Geometry checker (input side):
  - pix_cnt counts hsync strobes inside vsync. It clears on vsync rising edge.
  - line_cnt counts vsync falling edges inside fsync. It clears on fsync rising edge.
  - Neither counter wraps. Each saturates at its all-ones value.
- Error bits (sticky; all cleared on fsync rising edge and on reset):
  - bit0: at vsync fall, pix_cnt ≠ NB_IMG_HORI.
  - bit1: at fsync fall, line_cnt ≠ NB_IMG_VERT.
  - bit2: hsync=1 while vsync=0. The pixel is still converted and forwarded.
  - bit3: vsync=1 while fsync=0.
- Errors never stall or drop data.
- Simultaneous events:
  - fsync rise and an error condition in the same cycle: the clear wins for old flags, the new flag sets.
  - vsync fall and vsync rise cannot coincide. A one-cycle-low gap is legal.

## Timing
- Latency: 3 cycles for data and all three syncs. Input at cycle N gives output at cycle N+3.
- Throughput: one pixel per cycle.
- Reset values: all m_* outputs 0, pipeline valid bits 0, counters 0, error bus 0.
- Outputs are 0 in the first cycle after reset deasserts and stay 0 until 3 cycles after the first input strobe.
- Reset mid-frame:
  - The pipeline flushes immediately and output syncs drop to 0 on the next edge.
  - After release, the checker ignores the rest of the frame: error bits 0–1 stay masked until the next fsync rising edge.
- fsync rising edge is detected with a registered copy of the input. No combinational path exists from input to output.

## Test plan
- Pure colours, one pixel each; check m_img_gray_y_mdat0 exactly 3 cycles after each strobe:
  - R=255 → 77
  - G=255 → 149
  - B=255 → 29
  - white → 255
  - black → 0
- Pixel {10,20,30} → 18. Continuous hsync over 16 pixels → 16 output strobes on consecutive cycles, in order.
- Full 960×640 frame with strobes every other cycle:
  - Output syncs equal the input syncs shifted by 3.
  - Error bus stays 0.
  - Output pixel count is 614400.
- Line with 959 strobes → bit0 set at that vsync fall and held through the frame. Bit0 cleared at the next fsync rise.
- hsync pulse with vsync=0 → bit2 set and the pixel still appears at the output. vsync outside fsync → bit3 set.
- Assert i_sys_reset for 2 cycles mid-line:
  - All outputs 0 on the following edge.
  - No bit0/bit1 error reported for the truncated frame.
  - The next full frame converts correctly with the error bus at 0.
